// File: rtl/div_pkg.sv
// Shared definitions for the sequential sign-magnitude divider: FSM states,
// sign-bit index helpers and the zero-magnitude constant used by the flag logic.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Wide enough for any practical MAG_W; callers slice the low MAG_W bits.
    localparam logic [15:0] MAG_ZERO = 16'h0000;

    function automatic int unsigned op_sign_idx(input int unsigned mag_w);
        return mag_w;
    endfunction

    function automatic int unsigned res_sign_idx(input int unsigned mag_w);
        return 2 * mag_w;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// conditionally subtract the divisor and emit the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int MAG_W = 2
) (
    input  logic [MAG_W-1:0] prem,
    input  logic             din,
    input  logic [MAG_W-1:0] divisor,
    output logic [MAG_W-1:0] prem_next,
    output logic             qbit
);

    logic [MAG_W:0] shifted_s;

    assign shifted_s = {prem, din};

    // Compare and restore; when the subtraction is taken the result is below the divisor, so MAG_W bits suffice.
    always_comb begin
        prem_next = shifted_s[MAG_W-1:0];
        qbit      = 1'b0;
        if (shifted_s >= {1'b0, divisor}) begin
            prem_next = shifted_s[MAG_W-1:0] - divisor;
            qbit      = 1'b1;
        end else begin
            prem_next = shifted_s[MAG_W-1:0];
            qbit      = 1'b0;
        end
    end

endmodule

// File: rtl/seq_div.sv
// Sequential sign-magnitude divider: restoring loop, one quotient bit per cycle,
// start/busy/done handshake, registered quotient, remainder and flags.
module seq_div
    import div_pkg::*;
#(
    parameter int MAG_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAG_W:0]     A,
    input  logic [MAG_W:0]     B,
    output logic               busy,
    output logic               done,
    output logic [2*MAG_W:0]   R,
    output logic [MAG_W:0]     REM,
    output logic               SF,
    output logic               ZF,
    output logic               DZF
);

    localparam int unsigned      OS       = op_sign_idx(MAG_W);
    localparam int unsigned      RS       = res_sign_idx(MAG_W);
    localparam int unsigned      CNT_W    = (MAG_W > 1) ? $clog2(MAG_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAG_W - 1);
    localparam logic [MAG_W-1:0] ZERO_M   = MAG_ZERO[MAG_W-1:0];

    div_state_e       state_r, state_n;
    logic [MAG_W-1:0] a_sh_r, a_sh_n, b_mag_r, b_mag_n;
    logic [MAG_W-1:0] prem_r, prem_n, quo_r, quo_n;
    logic             sa_r, sa_n, sb_r, sb_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2*MAG_W:0] r_r, r_n;
    logic [MAG_W:0]   rem_r, rem_n;
    logic             sf_r, sf_n, zf_r, zf_n, dzf_r, dzf_n;
    logic [MAG_W-1:0] step_rem_s;
    logic             step_q_s;

    div_step #(.MAG_W(MAG_W)) u_step (
        .prem      (prem_r),
        .din       (a_sh_r[MAG_W-1]),
        .divisor   (b_mag_r),
        .prem_next (step_rem_s),
        .qbit      (step_q_s)
    );

    // Next-state and datapath update; result registers only change on a completion edge.
    always_comb begin
        state_n = state_r;
        a_sh_n  = a_sh_r;
        b_mag_n = b_mag_r;
        prem_n  = prem_r;
        quo_n   = quo_r;
        sa_n    = sa_r;
        sb_n    = sb_r;
        cnt_n   = cnt_r;
        r_n     = r_r;
        rem_n   = rem_r;
        sf_n    = sf_r;
        zf_n    = zf_r;
        dzf_n   = dzf_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_sh_n  = A[MAG_W-1:0];
                    b_mag_n = B[MAG_W-1:0];
                    sa_n    = A[OS];
                    sb_n    = B[OS];
                    prem_n  = ZERO_M;
                    quo_n   = ZERO_M;
                    cnt_n   = {CNT_W{1'b0}};
                    if (B[MAG_W-1:0] == ZERO_M) begin
                        state_n = DONE;
                        r_n     = {(2*MAG_W+1){1'b0}};
                        rem_n   = {(MAG_W+1){1'b0}};
                        sf_n    = 1'b0;
                        zf_n    = 1'b1;
                        dzf_n   = 1'b1;
                    end else begin
                        state_n = DIV;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            DIV: begin
                prem_n   = step_rem_s;
                quo_n    = quo_r << 1;
                quo_n[0] = step_q_s;
                a_sh_n   = a_sh_r << 1;
                cnt_n    = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_n            = DONE;
                    r_n                = {(2*MAG_W+1){1'b0}};
                    r_n[MAG_W-1:0]     = quo_n;
                    r_n[RS]            = (sa_r ^ sb_r) & (quo_n != ZERO_M);
                    rem_n              = {sa_r & (step_rem_s != ZERO_M), step_rem_s};
                    sf_n               = (sa_r ^ sb_r) & (quo_n != ZERO_M);
                    zf_n               = (quo_n == ZERO_M);
                    dzf_n              = 1'b0;
                end else begin
                    state_n = DIV;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_sh_r  <= ZERO_M;
            b_mag_r <= ZERO_M;
            prem_r  <= ZERO_M;
            quo_r   <= ZERO_M;
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            r_r     <= {(2*MAG_W+1){1'b0}};
            rem_r   <= {(MAG_W+1){1'b0}};
            sf_r    <= 1'b0;
            zf_r    <= 1'b0;
            dzf_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            a_sh_r  <= a_sh_n;
            b_mag_r <= b_mag_n;
            prem_r  <= prem_n;
            quo_r   <= quo_n;
            sa_r    <= sa_n;
            sb_r    <= sb_n;
            cnt_r   <= cnt_n;
            r_r     <= r_n;
            rem_r   <= rem_n;
            sf_r    <= sf_n;
            zf_r    <= zf_n;
            dzf_r   <= dzf_n;
        end
    end

    assign busy = (state_r != IDLE);
    assign done = (state_r == DONE);
    assign R    = r_r;
    assign REM  = rem_r;
    assign SF   = sf_r;
    assign ZF   = zf_r;
    assign DZF  = dzf_r;

endmodule
